// File: rtl/trace_scheduler.sv
// trace_scheduler: timestamped request FIFO that releases each head entry once the cycle counter reaches its time
module trace_scheduler #(
    parameter int ADDRESS_WIDTH = 33,
    parameter int TIME_WIDTH    = 64,
    parameter int DEPTH         = 8,
    parameter int OP_WIDTH      = 2,
    parameter int LATE_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_WIDTH-1:0]      in_time,
    input  logic [OP_WIDTH-1:0]        in_op,
    input  logic [ADDRESS_WIDTH-1:0]   in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_WIDTH-1:0]        out_op,
    output logic [ADDRESS_WIDTH-1:0]   out_addr,
    output logic [TIME_WIDTH-1:0]      out_time,
    output logic [TIME_WIDTH-1:0]      cycle,
    output logic [$clog2(DEPTH):0]     count,
    output logic [LATE_WIDTH-1:0]      late_count,
    output logic                       order_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [OP_WIDTH-1:0]      op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [TIME_WIDTH-1:0]    time_mem [DEPTH];
    logic [PW-1:0]            head, tail;
    logic [TIME_WIDTH-1:0]    last_time, store_time, head_time;
    logic                     push, pop, early, late_hit;

    assign head_time  = time_mem[head];
    assign in_ready   = rst_n && (count < CW'(DEPTH));
    assign out_valid  = rst_n && (count != '0) && (head_time <= cycle);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign early      = in_time < last_time;
    // Out-of-order arrivals are clamped so stored times never decrease.
    assign store_time = early ? last_time : in_time;
    assign late_hit   = pop && (cycle > head_time) && (late_count != '1);
    assign out_op     = out_valid ? op_mem[head]   : '0;
    assign out_addr   = out_valid ? addr_mem[head] : '0;
    assign out_time   = out_valid ? head_time      : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle      <= '0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            late_count <= '0;
            order_err  <= 1'b0;
            last_time  <= '0;
        end else begin
            cycle <= cycle + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                tail      <= tail + 1'b1;
                last_time <= store_time;
                order_err <= order_err | early;
            end
            if (pop)
                head <= head + 1'b1;
            if (late_hit)
                late_count <= late_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[tail]   <= in_op;
            addr_mem[tail] <= in_addr;
            time_mem[tail] <= store_time;
        end
    end
endmodule

// File: tb/tb_trace_scheduler.sv
// tb_trace_scheduler: scenario tasks plus a scoreboard that checks every popped entry in arrival order
module tb_trace_scheduler;
    typedef struct packed {
        logic [1:0]  op;
        logic [32:0] addr;
        logic [63:0] t;
    } ent_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic [63:0] in_time = 0;
    logic [1:0]  in_op = 0;
    logic [32:0] in_addr = 0;
    logic        out_ready = 0;
    logic        in_ready, out_valid, order_err;
    logic [1:0]  out_op;
    logic [32:0] out_addr;
    logic [63:0] out_time, cycle;
    logic [3:0]  count;
    logic [15:0] late_count;
    logic        s_in_ready, s_out_valid, s_order_err;
    logic [1:0]  s_out_op;
    logic [32:0] s_out_addr;
    logic [63:0] s_out_time, s_cycle;
    logic [3:0]  s_count;
    logic [1:0]  s_late_count;

    logic [63:0] tcyc = 0;
    int          passed = 0;
    int          total = 0;
    ent_t        q[$];

    trace_scheduler dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_addr(out_addr), .out_time(out_time), .cycle(cycle), .count(count),
        .late_count(late_count), .order_err(order_err)
    );

    trace_scheduler #(.LATE_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_op(s_out_op),
        .out_addr(s_out_addr), .out_time(s_out_time), .cycle(s_cycle), .count(s_count),
        .late_count(s_late_count), .order_err(s_order_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= rst_n ? tcyc + 1 : 64'd0;

    // Scoreboard: each handshake must match the oldest pushed entry and not precede its time.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (q.size() == 0)
                $display("FAIL pop_unexpected: cycle %0d got op=%0d addr=%0h time=%0d, no entry queued",
                         tcyc, out_op, out_addr, out_time);
            else if (out_op !== q[0].op || out_addr !== q[0].addr || out_time !== q[0].t || tcyc < q[0].t)
                $display("FAIL pop_data: cycle %0d got op=%0d addr=%0h time=%0d, want op=%0d addr=%0h time=%0d",
                         tcyc, out_op, out_addr, out_time, q[0].op, q[0].addr, q[0].t);
            else
                passed++;
            if (q.size() != 0)
                void'(q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        step();
        rst_n = 1;
        q.delete();
    endtask

    task automatic push_entry(input logic [63:0] t, input logic [1:0] op,
                              input logic [32:0] a, input logic [63:0] stored);
        in_valid = 1;
        in_time = t;
        in_op = op;
        in_addr = a;
        q.push_back('{op, a, stored});
    endtask

    task automatic wait_to(input logic [63:0] n);
        for (int k = 0; k < 200 && tcyc != n; k++)
            step();
    endtask

    task automatic test_basic();
        do_reset();
        step();
        out_ready = 1;
        push_entry(64'd5, 2'd1, 33'h1_0000_0040, 64'd5);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", in_ready); else passed++;
        step();
        in_valid = 0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'(c == 5)) $display("FAIL basic_valid: cycle %0d got %b want %b", c, out_valid, c == 5);
            else passed++;
            if (c == 2) begin
                total++;
                if (cycle !== 64'd2 || count !== 4'd1) $display("FAIL basic_state: got cycle=%0d count=%0d want 2/1", cycle, count);
                else passed++;
            end
            if (c == 3) begin
                total++;
                if (out_op !== 2'd0 || out_addr !== 33'd0 || out_time !== 64'd0)
                    $display("FAIL basic_gate: got op=%0d addr=%0h time=%0d want 0/0/0", out_op, out_addr, out_time);
                else passed++;
            end
            if (c == 5) begin
                total++;
                if (out_addr !== 33'h1_0000_0040) $display("FAIL basic_addr: got %0h want 100000040", out_addr);
                else passed++;
            end
            if (c == 6) begin
                total++;
                if (count !== 4'd0 || late_count !== 16'd0) $display("FAIL basic_end: got count=%0d late=%0d want 0/0", count, late_count);
                else passed++;
            end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_full();
        do_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            push_entry(64'd20, 2'(i % 3 + 1), 33'(i) * 33'h100 + 33'd7, 64'd20);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) $display("FAIL full_accept: entry %0d in_ready %b want 1", i, in_ready); else passed++;
            step();
        end
        in_valid = 1;
        in_addr = 33'h1ff;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || count !== 4'd8) $display("FAIL full_refuse: got in_ready=%b count=%0d want 0/8", in_ready, count);
        else passed++;
        step();
        in_valid = 0;
        wait_to(64'd25);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_time !== 64'd20 || out_addr !== 33'h7)
            $display("FAIL full_hold: got valid=%b time=%0d addr=%0h want 1/20/7", out_valid, out_time, out_addr);
        else passed++;
        wait_to(64'd30);
        out_ready = 1;
        for (int c = 30; c <= 38; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'(c <= 37)) $display("FAIL full_drain: cycle %0d got %b want %b", c, out_valid, c <= 37);
            else passed++;
            if (c == 38) begin
                total++;
                if (count !== 4'd0 || late_count !== 16'd8 || s_late_count !== 2'd3)
                    $display("FAIL full_late: got count=%0d late=%0d late2=%0d want 0/8/3", count, late_count, s_late_count);
                else passed++;
            end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_order();
        do_reset();
        step();
        push_entry(64'd10, 2'd2, 33'h0aa, 64'd10);
        step();
        push_entry(64'd4, 2'd3, 33'h0bb, 64'd10);
        @(negedge clk);
        total++;
        if (order_err !== 1'b0) $display("FAIL order_early: got %b want 0", order_err); else passed++;
        step();
        in_valid = 0;
        out_ready = 1;
        for (int c = 3; c <= 12; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'(c == 10 || c == 11)) $display("FAIL order_valid: cycle %0d got %b", c, out_valid);
            else passed++;
            if (c == 3) begin
                total++;
                if (order_err !== 1'b1) $display("FAIL order_flag: got %b want 1", order_err); else passed++;
            end
            if (c == 11) begin
                total++;
                if (out_time !== 64'd10) $display("FAIL order_clamp: got time=%0d want 10", out_time); else passed++;
            end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            push_entry(64'd0, 2'd1, 33'(i), 64'd0);
            step();
        end
        in_valid = 1;
        in_addr = 33'h99;
        out_ready = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL b2b_full: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        else passed++;
        step();
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        total++;
        if (count !== 4'd7) $display("FAIL b2b_count: got %0d want 7", count); else passed++;
        step();
        out_ready = 1;
        for (int k = 0; k < 20 && q.size() != 0; k++)
            step();
        @(negedge clk);
        total++;
        if (q.size() != 0 || count !== 4'd0) $display("FAIL b2b_drain: got count=%0d left=%0d want 0/0", count, q.size());
        else passed++;
        out_ready = 0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        push_entry(64'd3, 2'd1, 33'h10, 64'd3);
        step();
        for (int i = 1; i < 8; i++) begin
            push_entry(64'd0, 2'd2, 33'h10 + 33'(i), 64'd3);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        step();
        step();
        step();
        out_ready = 0;
        @(negedge clk);
        total++;
        if (count !== 4'd5 || late_count !== 16'd3 || order_err !== 1'b1)
            $display("FAIL rst_pre: got count=%0d late=%0d err=%b want 5/3/1", count, late_count, order_err);
        else passed++;
        step();
        rst_n = 0;
        in_valid = 1;
        out_ready = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_hold: got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        else passed++;
        step();
        rst_n = 1;
        in_valid = 0;
        out_ready = 0;
        q.delete();
        @(negedge clk);
        total++;
        if (count !== 4'd0 || cycle !== 64'd0 || late_count !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || order_err !== 1'b0)
            $display("FAIL rst_post: got count=%0d cycle=%0d late=%0d valid=%b ready=%b err=%b want 0/0/0/0/1/0",
                     count, cycle, late_count, out_valid, in_ready, order_err);
        else passed++;
    endtask

    task automatic test_late_sat();
        do_reset();
        step();
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            push_entry(64'd0, 2'd2, 33'h200 + 33'(i), 64'd0);
            if (i > 0) begin
                @(negedge clk);
                total++;
                if (out_valid !== 1'b1) $display("FAIL sat_stream: cycle %0d got %b want 1", tcyc, out_valid); else passed++;
            end
            step();
        end
        in_valid = 0;
        step();
        @(negedge clk);
        total++;
        if (late_count !== 16'd5 || s_late_count !== 2'd3 || count !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL sat_end: got late=%0d late2=%0d count=%0d valid=%b want 5/3/0/0", late_count, s_late_count, count, out_valid);
        else passed++;
        out_ready = 0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        total++;
        if (cycle !== 64'd0 || count !== 4'd0 || late_count !== 16'd0 || order_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_state: got cycle=%0d count=%0d late=%0d err=%b valid=%b ready=%b",
                     cycle, count, late_count, order_err, out_valid, in_ready);
        else passed++;
        test_basic();
        test_full();
        test_order();
        test_back_to_back();
        test_reset();
        test_late_sat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/trace_scheduler.md
# trace_scheduler

Timestamped memory-request scheduler between the trace front end and the memory-controller request queue. Accepts trace entries (release cycle, operation, address) over a valid/ready input, buffers up to DEPTH of them in arrival order, and presents each on a valid/ready output no earlier than its timestamp. Adds three things the single-entry trace strobe lacks: downstream backpressure, multi-entry buffering, and lateness/ordering accounting.

## Interface
- ADDRESS_WIDTH, 33: request address width.
- TIME_WIDTH, 64: timestamp and cycle-counter width.
- DEPTH, 8: buffer entries; power of two, at least 2.
- OP_WIDTH, 2: opcode width; value 0 is NOP.
- LATE_WIDTH, 16: late-counter width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  in  1  input entry present.
- in_ready  out  1  scheduler can accept an entry.
- in_time  in  TIME_WIDTH  requested release cycle.
- in_op  in  OP_WIDTH  opcode.
- in_addr  in  ADDRESS_WIDTH  address.
- out_valid  out  1  head entry is released.
- out_ready  in  1  downstream accepts the head.
- out_op  out  OP_WIDTH  head opcode.
- out_addr  out  ADDRESS_WIDTH  head address.
- out_time  out  TIME_WIDTH  stored head timestamp.
- cycle  out  TIME_WIDTH  current cycle count.
- count  out  $clog2(DEPTH)+1  occupied entries.
- late_count  out  LATE_WIDTH  number of late pops, saturating.
- order_err  out  1  sticky flag for a timestamp-order violation.

## Operation
- Reset sets, at the first edge with rst_n=0: cycle=0, count=0, head/tail pointers=0, late_count=0, order_err=0, last accepted time=0. All buffer contents are discarded.
- While in reset: in_ready=0 and out_valid=0.
- Reset mid-operation flushes everything; no pop or push completes on that edge.
- The cycle counter increments by 1 on every non-reset edge and wraps modulo 2^TIME_WIDTH. Comparisons across the wrap point are unsupported.
- Push: on an edge with in_valid && in_ready, the entry is written at tail and tail advances modulo DEPTH.
- Pop: on an edge with out_valid && out_ready, the head is removed.
- Full/empty:
  - in_ready = (count < DEPTH). When full, in_ready is 0 even if a pop happens the same cycle; no pass-through.
  - Push and pop in the same cycle leave count unchanged.
- Release rule: out_valid = (count != 0) && (head stored time <= cycle). Unsigned compare, combinational from registered state only.
- While out_valid=0: out_op=0, out_addr=0, out_time=0.
- While out_valid=1 and out_ready=0: the outputs hold stable and out_valid stays 1.
- Ordering: stored timestamps must be non-decreasing.
  - An accepted entry with in_time < last accepted time is stored with time = last accepted time, and order_err is set.
  - order_err clears only on reset.
  - The last accepted time updates to the stored (clamped) value on every push.
- Lateness: a pop with cycle > head stored time increments late_count, saturating at all-ones. A pop with cycle == stored time is on time.
- count, late_count and order_err are registered outputs.

## Timing
- Entry accepted at the edge ending cycle c reaches the head no earlier than cycle c+1. There is no same-cycle bypass.
- Minimum latency:
  - Entry pushed into an empty buffer at the edge ending cycle c, with stored time T, asserts out_valid in cycle max(c+1, T).
  - If T <= c, it is released in cycle c+1 and counts late when popped, since c+1 > T.
- Throughput: one push and one pop per cycle sustained.
- Entries with equal timestamps release on consecutive cycles in arrival order.
- A freshly reached head whose time has passed is valid immediately.
- Pop and late_count update take effect at the same edge; late_count is visible the following cycle.

## Test plan
- Reset then push (T=5, op=1, addr=0x1_0000_0040) in cycle 1 with out_ready=1 → out_valid only in cycle 5, out_addr=0x1_0000_0040; late_count=0; count returns to 0 in cycle 6.
- Push eight entries at T=20 with out_ready=0 → in_ready=0 after the 8th, count=8; a 9th in_valid is not accepted. Raise out_ready at cycle 30 → eight pops in cycles 30–37 in order, late_count=8.
- Push T=10 then T=4 → order_err=1 the cycle after the second push; second entry stored with out_time=10; both release at cycles 10 and 11.
- Full buffer with a simultaneous push and pop → the push is refused (in_ready=0) and count goes to 7.
- Assert rst_n=0 for one edge with count=5 and late_count=3 → next cycle: count=0, cycle=0, late_count=0, out_valid=0, in_ready=1 once rst_n=1.
- Set LATE_WIDTH=2 and force 5 late pops → late_count saturates at 3.
